// File: rtl/lsb_queue_mp.sv
`default_nettype none
// ============================================================================
//  Module   : lsb_queue_mp
//  Purpose  : In-order load/store queue. Entries are allocated in program
//             order, snoop NUM_WB writeback buses for pending operands, and
//             the head entry issues one outstanding memory request at a time.
//             Loads are sign/zero-extended; stores issue only at ROB head.
//  Options  : LSB_MMIO_EN - loads to addr[17:16]==2'b11 wait for ROB head.
//  Revision : 1.0 - initial release
// ============================================================================
module lsb_queue_mp #(
    parameter int DEPTH_BIT = 3,
    parameter int ROB_BIT   = 4,
    parameter int NUM_WB    = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      inst_valid,
    input  logic [3:0]                inst_op,
    input  logic [ROB_BIT-1:0]        inst_rob_idx,
    input  logic [31:0]               inst_r1,
    input  logic [31:0]               inst_r2,
    input  logic [ROB_BIT-1:0]        inst_dep1,
    input  logic [ROB_BIT-1:0]        inst_dep2,
    input  logic                      inst_has_dep1,
    input  logic                      inst_has_dep2,
    input  logic [11:0]               inst_offset,
    output logic                      full,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*ROB_BIT-1:0] wb_idx,
    input  logic [NUM_WB*32-1:0]      wb_value,
    input  logic                      rob_head_valid,
    input  logic [ROB_BIT-1:0]        rob_head_idx,
    output logic                      st_done,
    output logic [ROB_BIT-1:0]        st_done_idx,
    output logic                      lsb_wb_valid,
    output logic [ROB_BIT-1:0]        lsb_wb_idx,
    output logic [31:0]               lsb_wb_value,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_wr,
    output logic [1:0]                mem_len,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_done,
    input  logic [31:0]               mem_rdata
);

    localparam int                 DEPTH     = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] DEPTH_CNT = (DEPTH_BIT + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Queue storage
    logic [DEPTH-1:0]   ent_valid;
    logic [3:0]         ent_op   [DEPTH];
    logic [ROB_BIT-1:0] ent_tag  [DEPTH];
    logic [31:0]        ent_r1   [DEPTH];
    logic [31:0]        ent_r2   [DEPTH];
    logic [ROB_BIT-1:0] ent_dep1 [DEPTH];
    logic [ROB_BIT-1:0] ent_dep2 [DEPTH];
    logic               ent_has1 [DEPTH];
    logic               ent_has2 [DEPTH];
    logic [11:0]        ent_off  [DEPTH];

    logic [DEPTH_BIT-1:0] head;
    logic [DEPTH_BIT-1:0] tail;
    logic [DEPTH_BIT:0]   count;
    logic [DEPTH_BIT:0]   count_next;

    logic [1:0] state;
    logic [1:0] state_next;

    // Details of the request in flight; kept so a flushed store can still report
    logic               out_store;
    logic [ROB_BIT-1:0] out_tag;
    logic [2:0]         out_op;

    logic [32:0] snoop1 [DEPTH];
    logic [32:0] snoop2 [DEPTH];
    logic [32:0] push1;
    logic [32:0] push2;

    logic        pop;
    logic        push;
    logic        head_ready;
    logic        head_at_rob;
    logic        launchable;
    logic [31:0] head_addr;

    // Lowest-numbered writeback port carrying the tag; bit 32 flags a hit
    function automatic logic [32:0] wb_lookup(input logic [ROB_BIT-1:0] tag);
        logic [32:0] res;
        res = '0;
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (wb_valid[k] && (wb_idx[k*ROB_BIT +: ROB_BIT] == tag)) begin
                res = {1'b1, wb_value[k*32 +: 32]};
            end
        end
        return res;
    endfunction

    // Narrow load data is widened according to size and signedness
    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] op);
        logic [31:0] res;
        case (op[1:0])
            2'd0:    res = op[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    res = op[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Writeback matches for every stored entry and for the incoming instruction
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snoop1[i] = wb_lookup(ent_dep1[i]);
            snoop2[i] = wb_lookup(ent_dep2[i]);
        end
        push1 = wb_lookup(inst_dep1);
        push2 = wb_lookup(inst_dep2);
    end

    assign head_addr   = ent_r1[head] + {{20{ent_off[head][11]}}, ent_off[head]};
    assign head_ready  = ent_valid[head] && !ent_has1[head] && !ent_has2[head];
    assign head_at_rob = rob_head_valid && (rob_head_idx == ent_tag[head]);

    // Stores are non-speculative; loads go as soon as operands are ready
    always_comb begin
        launchable = 1'b0;
        if (ent_op[head][3]) begin
            launchable = head_ready && head_at_rob;
        end else begin
`ifdef LSB_MMIO_EN
            launchable = head_ready && ((head_addr[17:16] != 2'b11) || head_at_rob);
`else
            launchable = head_ready;
`endif
        end
    end

    assign pop        = (state == ST_WAIT) && mem_done && !flush_in;
    assign push       = inst_valid && !flush_in && (!full || pop);
    assign count_next = count + {{DEPTH_BIT{1'b0}}, push} - {{DEPTH_BIT{1'b0}}, pop};

    // Memory FSM state register; a stall freezes it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // Memory FSM next state; a flush turns an outstanding access into a drain
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (mem_valid && mem_ready) begin
                    state_next = flush_in ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    state_next = ST_IDLE;
                end else if (flush_in) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request fields straight from the head entry; zero when nothing is offered
    always_comb begin
        mem_valid = 1'b0;
        mem_wr    = 1'b0;
        mem_len   = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if ((state == ST_IDLE) && launchable) begin
            mem_valid = 1'b1;
            mem_wr    = ent_op[head][3];
            mem_len   = ent_op[head][1:0];
            mem_addr  = head_addr;
            mem_wdata = ent_r2[head];
        end
    end

    // Entry storage: snoop, pop at head, push at tail; flush empties the queue
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            full      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_op[i]   <= '0;
                ent_tag[i]  <= '0;
                ent_r1[i]   <= '0;
                ent_r2[i]   <= '0;
                ent_dep1[i] <= '0;
                ent_dep2[i] <= '0;
                ent_has1[i] <= 1'b0;
                ent_has2[i] <= 1'b0;
                ent_off[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                ent_valid <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                full      <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_valid[i] && ent_has1[i] && snoop1[i][32]) begin
                        ent_r1[i]   <= snoop1[i][31:0];
                        ent_has1[i] <= 1'b0;
                    end
                    if (ent_valid[i] && ent_has2[i] && snoop2[i][32]) begin
                        ent_r2[i]   <= snoop2[i][31:0];
                        ent_has2[i] <= 1'b0;
                    end
                end
                if (pop) begin
                    ent_valid[head] <= 1'b0;
                    head            <= head + 1'b1;
                end
                // When full, the slot at tail is the one being popped, so push overrides it
                if (push) begin
                    ent_valid[tail] <= 1'b1;
                    ent_op[tail]    <= inst_op;
                    ent_tag[tail]   <= inst_rob_idx;
                    ent_dep1[tail]  <= inst_dep1;
                    ent_dep2[tail]  <= inst_dep2;
                    ent_off[tail]   <= inst_offset;
                    ent_r1[tail]    <= (inst_has_dep1 && push1[32]) ? push1[31:0] : inst_r1;
                    ent_r2[tail]    <= (inst_has_dep2 && push2[32]) ? push2[31:0] : inst_r2;
                    ent_has1[tail]  <= inst_has_dep1 && !push1[32];
                    ent_has2[tail]  <= inst_has_dep2 && !push2[32];
                    tail            <= tail + 1'b1;
                end
                count <= count_next;
                full  <= (count_next == DEPTH_CNT);
            end
        end
    end

    // Capture the launched request so completion does not depend on the queue
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_store <= 1'b0;
            out_tag   <= '0;
            out_op    <= '0;
        end else if (rdy_in && mem_valid && mem_ready) begin
            out_store <= ent_op[head][3];
            out_tag   <= ent_tag[head];
            out_op    <= ent_op[head][2:0];
        end
    end

    // Completion reporting: load result or store-done pulse, one cycle after mem_done
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lsb_wb_valid <= 1'b0;
            lsb_wb_idx   <= '0;
            lsb_wb_value <= '0;
            st_done      <= 1'b0;
            st_done_idx  <= '0;
        end else if (rdy_in) begin
            lsb_wb_valid <= 1'b0;
            st_done      <= 1'b0;
            if (mem_done && ((state == ST_WAIT) || (state == ST_DRAIN))) begin
                if (out_store) begin
                    st_done     <= 1'b1;
                    st_done_idx <= out_tag;
                end else if ((state == ST_WAIT) && !flush_in) begin
                    lsb_wb_valid <= 1'b1;
                    lsb_wb_idx   <= out_tag;
                    lsb_wb_value <= extend_load(mem_rdata, out_op);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsb_queue_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsb_queue_mp
//  Purpose  : Self-checking bench for lsb_queue_mp: directed scenarios with
//             literal expectations, then randomized traffic compared every
//             cycle against a queue-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsb_queue_mp;

    localparam int DEPTH_BIT = 3;
    localparam int ROB_BIT   = 4;
    localparam int NUM_WB    = 2;
    localparam int DEPTH     = 8;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        inst_valid;
    logic [3:0]  inst_op;
    logic [3:0]  inst_rob_idx;
    logic [31:0] inst_r1;
    logic [31:0] inst_r2;
    logic [3:0]  inst_dep1;
    logic [3:0]  inst_dep2;
    logic        inst_has_dep1;
    logic        inst_has_dep2;
    logic [11:0] inst_offset;
    logic        full;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_idx;
    logic [63:0] wb_value;
    logic        rob_head_valid;
    logic [3:0]  rob_head_idx;
    logic        st_done;
    logic [3:0]  st_done_idx;
    logic        lsb_wb_valid;
    logic [3:0]  lsb_wb_idx;
    logic [31:0] lsb_wb_value;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wr;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    always #5 clk_in = ~clk_in;

    lsb_queue_mp #(.DEPTH_BIT(DEPTH_BIT), .ROB_BIT(ROB_BIT), .NUM_WB(NUM_WB)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .inst_valid(inst_valid), .inst_op(inst_op), .inst_rob_idx(inst_rob_idx),
        .inst_r1(inst_r1), .inst_r2(inst_r2), .inst_dep1(inst_dep1), .inst_dep2(inst_dep2),
        .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2), .inst_offset(inst_offset),
        .full(full), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
        .rob_head_valid(rob_head_valid), .rob_head_idx(rob_head_idx),
        .st_done(st_done), .st_done_idx(st_done_idx),
        .lsb_wb_valid(lsb_wb_valid), .lsb_wb_idx(lsb_wb_idx), .lsb_wb_value(lsb_wb_value),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  dep1;
        logic [3:0]  dep2;
        logic        has1;
        logic        has2;
        logic [11:0] off;
    } ent_t;

    ent_t        mq[$];
    bit          m_busy    = 1'b0;   // a request is with the memory
    bit          m_discard = 1'b0;   // its queue entry has been flushed away
    logic        m_ostore  = 1'b0;
    logic [3:0]  m_otag    = 4'd0;
    logic [3:0]  m_oop     = 4'd0;
    logic        m_wbv     = 1'b0;
    logic [3:0]  m_wbi     = 4'd0;
    logic [31:0] m_wbd     = 32'd0;
    logic        m_st      = 1'b0;
    logic [3:0]  m_sti     = 4'd0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] find_wb(input logic [3:0] tag);
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_idx[k*ROB_BIT +: ROB_BIT] == tag)) return {1'b1, wb_value[k*32 +: 32]};
        end
        return 33'd0;
    endfunction

    function automatic logic [31:0] ent_addr(input ent_t e);
        return e.r1 + 32'($signed(e.off));
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] raw, input logic [3:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[7:0];
        h = raw[15:0];
        if (op[1:0] == 2'd0) return op[2] ? 32'(b) : 32'($signed(b));
        if (op[1:0] == 2'd1) return op[2] ? 32'(h) : 32'($signed(h));
        return raw;
    endfunction

    function automatic bit exp_mem_valid();
        ent_t e;
        bit   at_rob;
        if (m_busy || mq.size() == 0) return 1'b0;
        e = mq[0];
        if (e.has1 || e.has2) return 1'b0;
        at_rob = rob_head_valid && (rob_head_idx == e.tag);
        if (e.op[3]) return at_rob;
`ifdef LSB_MMIO_EN
        if (ent_addr(e)[17:16] == 2'b11) return at_rob;
`endif
        return 1'b1;
    endfunction

    task automatic model_step();
        bit   mv;
        bit   pop;
        bit   can_push;
        ent_t e;
        logic [32:0] h;
        mv  = exp_mem_valid();
        pop = m_busy && !m_discard && mem_done && !flush_in;
        m_wbv = 1'b0;
        m_st  = 1'b0;
        if (m_busy && mem_done) begin
            if (m_ostore) begin
                m_st  = 1'b1;
                m_sti = m_otag;
            end else if (!m_discard && !flush_in) begin
                m_wbv = 1'b1;
                m_wbi = m_otag;
                m_wbd = load_value(mem_rdata, m_oop);
            end
            m_busy = 1'b0;
        end else if (m_busy && flush_in) begin
            m_discard = 1'b1;
        end else if (mv && mem_ready) begin
            m_busy    = 1'b1;
            m_discard = flush_in;
            m_ostore  = mq[0].op[3];
            m_otag    = mq[0].tag;
            m_oop     = mq[0].op;
        end
        can_push = inst_valid && !flush_in && ((mq.size() < DEPTH) || pop);
        foreach (mq[i]) begin
            if (mq[i].has1) begin
                h = find_wb(mq[i].dep1);
                if (h[32]) begin mq[i].r1 = h[31:0]; mq[i].has1 = 1'b0; end
            end
            if (mq[i].has2) begin
                h = find_wb(mq[i].dep2);
                if (h[32]) begin mq[i].r2 = h[31:0]; mq[i].has2 = 1'b0; end
            end
        end
        if (pop) void'(mq.pop_front());
        if (can_push) begin
            e.op = inst_op;  e.tag = inst_rob_idx;  e.off = inst_offset;
            e.dep1 = inst_dep1;  e.dep2 = inst_dep2;
            e.r1 = inst_r1;  e.r2 = inst_r2;
            e.has1 = inst_has_dep1;  e.has2 = inst_has_dep2;
            if (e.has1) begin h = find_wb(e.dep1); if (h[32]) begin e.r1 = h[31:0]; e.has1 = 1'b0; end end
            if (e.has2) begin h = find_wb(e.dep2); if (h[32]) begin e.r2 = h[31:0]; e.has2 = 1'b0; end end
            mq.push_back(e);
        end
        if (flush_in) mq.delete();
    endtask

    // Model advances on the same edge as the DUT, from the bench-held inputs
    always @(posedge clk_in) begin
        if (!rst_n_in) begin
            mq.delete();
            m_busy = 1'b0;  m_discard = 1'b0;
            m_wbv = 1'b0;   m_st = 1'b0;
        end else if (rdy_in) begin
            model_step();
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk_in) begin
        ent_t e;
        bit   mv;
        #2;
        mv = exp_mem_valid();
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("mem_valid", 32'(mem_valid), 32'(mv));
        if (mv && mq.size() > 0) begin
            e = mq[0];
            check("mem_wr", 32'(mem_wr), 32'(e.op[3]));
            check("mem_len", 32'(mem_len), 32'(e.op[1:0]));
            check("mem_addr", mem_addr, ent_addr(e));
            check("mem_wdata", mem_wdata, e.r2);
        end
        check("lsb_wb_valid", 32'(lsb_wb_valid), 32'(m_wbv));
        if (m_wbv) begin
            check("lsb_wb_idx", 32'(lsb_wb_idx), 32'(m_wbi));
            check("lsb_wb_value", lsb_wb_value, m_wbd);
        end
        check("st_done", 32'(st_done), 32'(m_st));
        if (m_st) check("st_done_idx", 32'(st_done_idx), 32'(m_sti));
    end

    // ---------------- directed helpers ----------------
    task automatic push(input logic [3:0] op, input logic [3:0] tag, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [11:0] off,
                        input logic hd1, input logic [3:0] d1);
        inst_valid = 1'b1;  inst_op = op;  inst_rob_idx = tag;
        inst_r1 = r1;  inst_r2 = r2;  inst_offset = off;
        inst_has_dep1 = hd1;  inst_dep1 = d1;
        inst_has_dep2 = 1'b0;  inst_dep2 = 4'd0;
        @(negedge clk_in);
        inst_valid = 1'b0;  inst_has_dep1 = 1'b0;
    endtask

    // Accept the offered request, complete it next cycle, return when the result is visible
    task automatic serve(input logic [31:0] rd);
        mem_ready = 1'b1;
        @(negedge clk_in);
        mem_ready = 1'b0;  mem_done = 1'b1;  mem_rdata = rd;
        @(negedge clk_in);
        mem_done = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0;  rdy_in = 1'b1;  flush_in = 1'b0;
        inst_valid = 1'b0;  inst_op = 4'd0;  inst_rob_idx = 4'd0;
        inst_r1 = 32'd0;  inst_r2 = 32'd0;  inst_dep1 = 4'd0;  inst_dep2 = 4'd0;
        inst_has_dep1 = 1'b0;  inst_has_dep2 = 1'b0;  inst_offset = 12'd0;
        wb_valid = 2'd0;  wb_idx = 8'd0;  wb_value = 64'd0;
        rob_head_valid = 1'b0;  rob_head_idx = 4'd0;
        mem_ready = 1'b0;  mem_done = 1'b0;  mem_rdata = 32'd0;

        repeat (3) @(negedge clk_in);
        #3;
        check("rst full", 32'(full), 32'd0);
        check("rst mem_valid", 32'(mem_valid), 32'd0);
        check("rst st_done", 32'(st_done), 32'd0);
        check("rst lsb_wb_valid", 32'(lsb_wb_valid), 32'd0);
        check("rst lsb_wb_value", lsb_wb_value, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // LB / LBU with negative offset
        push(4'b0000, 4'd3, 32'h100, 32'd0, 12'hFFC, 1'b0, 4'd0);
        #3;
        check("lb mem_valid", 32'(mem_valid), 32'd1);
        check("lb mem_addr", mem_addr, 32'h0000_00FC);
        check("lb mem_len", 32'(mem_len), 32'd0);
        serve(32'h80);
        #3;
        check("lb wb_valid", 32'(lsb_wb_valid), 32'd1);
        check("lb wb_idx", 32'(lsb_wb_idx), 32'd3);
        check("lb wb_value", lsb_wb_value, 32'hFFFF_FF80);
        @(negedge clk_in);
        push(4'b0100, 4'd3, 32'h100, 32'd0, 12'hFFC, 1'b0, 4'd0);
        #3;
        check("lbu mem_addr", mem_addr, 32'h0000_00FC);
        serve(32'h80);
        #3;
        check("lbu wb_value", lsb_wb_value, 32'h0000_0080);
        @(negedge clk_in);

        // Store waits for its operand, then for the ROB head
        push(4'b1010, 4'd5, 32'd0, 32'hDEAD_BEEF, 12'h010, 1'b1, 4'd2);
        #3;
        check("st dep mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clk_in);
        wb_valid = 2'b10;  wb_idx = {4'd2, 4'd0};  wb_value = {32'h0000_2000, 32'd0};
        @(negedge clk_in);
        wb_valid = 2'b00;
        #3;
        check("st rob mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clk_in);
        rob_head_valid = 1'b1;  rob_head_idx = 4'd5;
        #3;
        check("st mem_valid", 32'(mem_valid), 32'd1);
        check("st mem_wr", 32'(mem_wr), 32'd1);
        check("st mem_addr", mem_addr, 32'h0000_2010);
        check("st mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        serve(32'd0);
        #3;
        check("st_done pulse", 32'(st_done), 32'd1);
        check("st_done_idx", 32'(st_done_idx), 32'd5);
        @(negedge clk_in);
        rob_head_valid = 1'b0;
        #3;
        check("st_done clears", 32'(st_done), 32'd0);
        @(negedge clk_in);

        // Fill to full, overflow push ignored, drain in order
        for (int i = 0; i < 8; i++) push(4'b0010, 4'(i), 32'h1000 * i, 32'd0, 12'd4, 1'b0, 4'd0);
        #3;
        check("fill full", 32'(full), 32'd1);
        @(negedge clk_in);
        push(4'b0010, 4'd8, 32'h9999, 32'd0, 12'd0, 1'b0, 4'd0);
        #3;
        check("overflow full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("drain addr", mem_addr, 32'h1000 * i + 32'd4);
            serve(32'hA0 + i);
            #3;
            check("drain idx", 32'(lsb_wb_idx), 32'(i));
        end
        check("drained full", 32'(full), 32'd0);
        @(negedge clk_in);
        #3;
        check("drained mem_valid", 32'(mem_valid), 32'd0);

        // Flush while a load is outstanding
        @(negedge clk_in);
        push(4'b0010, 4'd4, 32'h40, 32'd0, 12'd0, 1'b0, 4'd0);
        mem_ready = 1'b1;
        @(negedge clk_in);
        mem_ready = 1'b0;  flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        #3;
        check("drain mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clk_in);
        push(4'b0010, 4'd6, 32'h60, 32'd0, 12'd0, 1'b0, 4'd0);
        #3;
        check("drain hold mem_valid", 32'(mem_valid), 32'd0);
        mem_done = 1'b1;  mem_rdata = 32'h1111;
        @(negedge clk_in);
        mem_done = 1'b0;
        #3;
        check("flushed no wb", 32'(lsb_wb_valid), 32'd0);
        check("post-flush mem_addr", mem_addr, 32'h60);
        serve(32'h22);
        #3;
        check("post-flush idx", 32'(lsb_wb_idx), 32'd6);
        check("post-flush full", 32'(full), 32'd0);

        // Push and pop together while full
        @(negedge clk_in);
        for (int i = 0; i < 8; i++) push(4'b0010, 4'(8 + i), 32'h100 * i, 32'd0, 12'd0, 1'b0, 4'd0);
        mem_ready = 1'b1;
        @(negedge clk_in);
        mem_ready = 1'b0;  mem_done = 1'b1;  mem_rdata = 32'h1234;
        push(4'b0010, 4'd2, 32'h2222, 32'd0, 12'd0, 1'b0, 4'd0);
        mem_done = 1'b0;
        #3;
        check("pp full", 32'(full), 32'd1);
        check("pp idx", 32'(lsb_wb_idx), 32'd8);
        for (int i = 0; i < 8; i++) serve(32'h55);
        #3;
        check("pp last idx", 32'(lsb_wb_idx), 32'd2);
        check("pp empty", 32'(full), 32'd0);

        // MMIO-range load
        @(negedge clk_in);
        push(4'b0010, 4'd7, 32'h0003_0000, 32'd0, 12'd0, 1'b0, 4'd0);
`ifdef LSB_MMIO_EN
        for (int i = 0; i < 3; i++) begin
            #3;
            check("mmio blocked", 32'(mem_valid), 32'd0);
            @(negedge clk_in);
        end
        rob_head_valid = 1'b1;  rob_head_idx = 4'd7;
`endif
        #3;
        check("mmio launch", 32'(mem_valid), 32'd1);
        serve(32'h77);
        rob_head_valid = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_in);
            rdy_in        = ($urandom_range(0, 9) != 0);
            flush_in      = ($urandom_range(0, 49) == 0);
            inst_valid    = 1'($urandom_range(0, 1));
            inst_op       = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            inst_rob_idx  = 4'($urandom);
            inst_r1       = $urandom;
            inst_r2       = $urandom;
            inst_offset   = 12'($urandom);
            inst_dep1     = 4'($urandom);
            inst_dep2     = 4'($urandom);
            inst_has_dep1 = ($urandom_range(0, 2) == 0);
            inst_has_dep2 = ($urandom_range(0, 2) == 0);
            wb_valid      = 2'($urandom);
            wb_idx        = 8'($urandom);
            wb_value      = {$urandom, $urandom};
            rob_head_valid = ($urandom_range(0, 4) != 0);
            rob_head_idx   = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].tag : 4'($urandom);
            mem_ready     = 1'($urandom_range(0, 1));
            mem_done      = m_busy && ($urandom_range(0, 2) == 0);
            mem_rdata     = $urandom;
        end
        @(negedge clk_in);
        rdy_in = 1'b1;  flush_in = 1'b0;  inst_valid = 1'b0;  wb_valid = 2'd0;
        mem_ready = 1'b0;  mem_done = 1'b0;
        repeat (3) @(negedge clk_in);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsb_queue_mp.md
Name: lsb_queue_mp

Overview:
Parametrised in-order load/store queue sitting between the issue stage, the ROB and the memory interface. Entries are allocated in program order and snoop NUM_WB writeback buses for operands. The head entry drives a single-outstanding memory request with a valid/ready/done handshake. Loads are sign- or zero-extended internally, and stores are released only at ROB head.

Parameters:
DEPTH_BIT, 3, log2 of queue depth (DEPTH = 1<<DEPTH_BIT).
ROB_BIT, 4, width of ROB index.
NUM_WB, 2, number of writeback (CDB) ports snooped.

Ports:
clk_in  in  1  clock
rst_n_in  in  1  reset; one clock; reset is asynchronous and active-low
rdy_in  in  1  global stall; low freezes all state (outputs hold)
flush_in  in  1  ROB misprediction flush
inst_valid  in  1  allocate entry this cycle
inst_op  in  4  [3]=store, [2]=unsigned load, [1:0]=size (0 B, 1 H, 2 W)
inst_rob_idx  in  ROB_BIT  destination/ROB tag
inst_r1, inst_r2  in  32 each  base address / store data values
inst_dep1, inst_dep2  in  ROB_BIT each  producer tags
inst_has_dep1, inst_has_dep2  in  1 each  operand pending
inst_offset  in  12  signed immediate
full  out  1  registered; count==DEPTH
wb_valid  in  NUM_WB  per-port writeback valid
wb_idx  in  NUM_WB*ROB_BIT  packed tags, port k at [k*ROB_BIT +: ROB_BIT]
wb_value  in  NUM_WB*32  packed values
rob_head_valid, rob_head_idx  in  1, ROB_BIT  current ROB head
st_done  out  1  one-cycle pulse: head store completed
st_done_idx  out  ROB_BIT  its tag
lsb_wb_valid, lsb_wb_idx, lsb_wb_value  out  1, ROB_BIT, 32  registered load result
mem_valid  out  1  request valid
mem_ready  in  1  request accepted
mem_wr, mem_len, mem_addr, mem_wdata  out  1, 2, 32, 32  request fields
mem_done  in  1  access complete
mem_rdata  in  32  raw little-endian data, low bytes valid

Behaviour:
- Reset: all entries invalid; head=tail=count=0; state IDLE. full, mem_valid, st_done, lsb_wb_valid all 0; other outputs 0.
- Push: when inst_valid and !full, write the entry at tail, then tail++ (wraps mod DEPTH) and count++. inst_valid while full is ignored.
- Operand capture at push: if has_dep and any wb port k matches dep, take that value and clear has_dep. Lowest k wins.
- Snoop: each cycle, every valid entry with a pending dep captures a matching wb port value (lowest k wins).
- Address: addr = r1 + sext(offset), mod 2^32.
- FSM IDLE:
  - Head entry is launchable when valid, has no deps, and either it is a load, or it is a store with rob_head_valid && rob_head_idx==entry tag.
  - mem_valid is combinational from head in IDLE. mem_wr=op[3], mem_len=op[1:0], mem_wdata=r2.
  - On mem_valid && mem_ready, go to WAIT. The fields must not change while mem_valid is held without mem_ready.
- FSM WAIT: on mem_done, pop the head (head++, count--) and return to IDLE.
  - Load: next cycle lsb_wb_valid=1, lsb_wb_idx=tag, lsb_wb_value = extended mem_rdata (B/H sign- or zero-extended per op[2]; W passed through).
  - Store: st_done pulses for one cycle with st_done_idx.
- Push and pop in the same cycle leave count unchanged. full is recomputed from the next count.
- Flush: clears all entries, head, tail and count; lsb_wb_valid is forced 0.
  - From WAIT with a load outstanding, go to DRAIN: wait for mem_done, discard the data, then go to IDLE. mem_valid=0 in DRAIN.
  - A store cannot be outstanding at flush, because the ROB head blocks. If one is, it completes and st_done still pulses.
  - A push in the flush cycle is dropped.
- Misaligned accesses are not checked; the address is passed through unchanged.
- rdy_in low: no state changes. mem_valid stays asserted if it was already high.

Optional Feature:
LSB_MMIO_EN. When defined, a load whose addr[17:16]==2'b11 is launchable only when rob_head_valid && rob_head_idx==its tag (non-speculative I/O read). When undefined, loads launch as soon as their operands are ready.

Test Plan:
- Load: push LB tag 3, r1=0x100, offset=-4, mem_rdata=0x80 -> mem_addr=0xFC, mem_len=0. The cycle after mem_done: lsb_wb_valid=1, idx=3, value=0xFFFFFF80. Same with LBU -> value 0x00000080.
- Operand snoop: push store tag 5 with has_dep1, dep1=2; drive wb port1 idx 2 value 0x2000 two cycles later; then set rob_head_idx=5 -> mem_wr=1, mem_addr=0x2000+offset. mem_done -> st_done pulse, st_done_idx=5.
- Full/wrap: push 8 loads with mem_ready=0 -> full=1 after the 8th; 9th push is ignored. Complete all 8 -> head wraps to 0, full=0, count=0.
- Flush in WAIT: load outstanding, assert flush_in -> mem_valid=0 until mem_done. No lsb_wb_valid for the flushed tag; queue is empty afterwards.
- Simultaneous push/pop at count=8 with mem_done -> count stays 8 and full stays 1; the new entry lands at the old head slot.
- MMIO (LSB_MMIO_EN): load tag 7 to 0x30000 -> mem_valid stays 0 until rob_head_idx=7.
